// File: rtl/video_ctrl_pkg.sv
// Shared types for the video path controller: lock FSM states and processing-mode codes.
package video_ctrl_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_GREY = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/video_timing_meter.sv
// Samples vs/hs/de, emits 1-cycle frame/line start pulses, and measures line width and line count per frame.
// Frame snapshot (eval_w/eval_h/frame_ok) is valid while frame_start is high; no backpressure.
module video_timing_meter #(
    parameter int H_CNT_W = 12,
    parameter int V_CNT_W = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vs_in,
    input  logic               hs_in,
    input  logic               de_in,
    input  logic               armed,
    output logic               frame_start,
    output logic               line_start,
    output logic               frame_ok,
    output logic [H_CNT_W-1:0] eval_w,
    output logic [V_CNT_W-1:0] eval_h
);

    logic               vs_d, hs_d, de_d;
    logic [H_CNT_W-1:0] pix_cnt, frame_w, fw_nxt;
    logic [V_CNT_W-1:0] line_cnt;
    logic               line_mm, mm_nxt, snap_valid;
    logic               vs_rise, de_rise, de_fall;
    logic               unused_hs;

    assign vs_rise   = vs_in & ~vs_d;
    assign de_rise   = de_in & ~de_d;
    assign de_fall   = ~de_in & de_d;
    assign frame_ok  = armed & snap_valid;
    assign unused_hs = hs_d;

    // A line ending on the same edge as vs rising still belongs to the old frame.
    always_comb begin
        fw_nxt = frame_w;
        mm_nxt = line_mm;
        if (de_fall) begin
            if (frame_w == '0)
                fw_nxt = pix_cnt;
            else if (pix_cnt != frame_w)
                mm_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_d        <= 1'b0;
            hs_d        <= 1'b0;
            de_d        <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            pix_cnt     <= '0;
            frame_w     <= '0;
            line_mm     <= 1'b0;
            line_cnt    <= '0;
            eval_w      <= '0;
            eval_h      <= '0;
            snap_valid  <= 1'b0;
        end else begin
            vs_d        <= vs_in;
            hs_d        <= hs_in;
            de_d        <= de_in;
            frame_start <= vs_rise;
            line_start  <= de_rise;

            if (de_in)
                pix_cnt <= (pix_cnt == '1) ? pix_cnt : pix_cnt + H_CNT_W'(1);
            else
                pix_cnt <= '0;

            // A line starting on the vs edge is counted in the new frame.
            if (vs_rise) begin
                eval_w     <= fw_nxt;
                eval_h     <= line_cnt;
                snap_valid <= (fw_nxt != '0) && (line_cnt != '0) && !mm_nxt;
                frame_w    <= '0;
                line_mm    <= 1'b0;
                line_cnt   <= de_rise ? V_CNT_W'(1) : '0;
            end else begin
                frame_w <= fw_nxt;
                line_mm <= mm_nxt;
                if (de_rise && line_cnt != '1)
                    line_cnt <= line_cnt + V_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_path_ctrl.sv
// Timing lock FSM, frame watchdog and frame-aligned processing-mode handshake for the HDMI pixel path.
// Mode applies at next frame_start when locked, else 1 cycle after accept; one request in flight (ready low while pending).
module video_path_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int H_CNT_W     = 12,
    parameter int V_CNT_W     = 12,
    parameter int LOCK_FRAMES = 2,
    parameter int WDOG_W      = 24,
    parameter int MODE_W      = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vs_in,
    input  logic               hs_in,
    input  logic               de_in,
    input  logic [MODE_W-1:0]  mode_req,
    input  logic               mode_req_valid,
    output logic               mode_req_ready,
    output logic [MODE_W-1:0]  mode_active,
    output logic               mode_update,
    output logic               frame_start,
    output logic               line_start,
    output logic [H_CNT_W-1:0] h_active,
    output logic [V_CNT_W-1:0] v_active,
    output logic               timing_locked,
    output logic               timing_err
);

    localparam int MC_W = $clog2(LOCK_FRAMES + 1);

    lock_state_t        state, state_n;
    logic [MC_W-1:0]    match_cnt, match_n, match_inc;
    logic               armed, armed_n, err_n, load_dims, same_dims;
    logic               frame_ok;
    logic [H_CNT_W-1:0] eval_w;
    logic [V_CNT_W-1:0] eval_h;
    logic [WDOG_W-1:0]  wdog;
    logic               wdog_to;
    logic               pending, accept, apply;
    logic [MODE_W-1:0]  pend_mode;

    video_timing_meter #(
        .H_CNT_W (H_CNT_W),
        .V_CNT_W (V_CNT_W)
    ) u_meter (
        .clk         (clk),
        .rstn        (rstn),
        .vs_in       (vs_in),
        .hs_in       (hs_in),
        .de_in       (de_in),
        .armed       (armed),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_ok    (frame_ok),
        .eval_w      (eval_w),
        .eval_h      (eval_h)
    );

    assign wdog_to       = (wdog == '1) && !frame_start;
    assign same_dims     = (eval_w == h_active) && (eval_h == v_active);
    assign match_inc     = match_cnt + MC_W'(1);
    assign timing_locked = (state == LOCKED);

    always_comb begin
        state_n   = state;
        match_n   = match_cnt;
        armed_n   = armed;
        err_n     = 1'b0;
        load_dims = 1'b0;
        if (wdog_to) begin
            // Stalled source: forget history so the next frame is treated as partial.
            state_n = UNLOCKED;
            armed_n = 1'b0;
            match_n = '0;
            err_n   = (state == LOCKED);
        end else if (frame_start) begin
            if (!armed) begin
                armed_n = 1'b1;
            end else begin
                load_dims = frame_ok;
                case (state)
                    UNLOCKED: begin
                        if (frame_ok) begin
                            state_n = LOCKING;
                            match_n = MC_W'(1);
                        end
                    end
                    LOCKING: begin
                        if (frame_ok && same_dims) begin
                            match_n = match_inc;
                            if (match_inc >= MC_W'(LOCK_FRAMES))
                                state_n = LOCKED;
                        end else if (frame_ok) begin
                            match_n = MC_W'(1);
                        end else begin
                            state_n = UNLOCKED;
                            match_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (!(frame_ok && same_dims)) begin
                            state_n = UNLOCKED;
                            match_n = '0;
                            err_n   = 1'b1;
                        end
                    end
                    default: begin
                        state_n = UNLOCKED;
                        match_n = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= UNLOCKED;
            match_cnt  <= '0;
            armed      <= 1'b0;
            timing_err <= 1'b0;
            h_active   <= '0;
            v_active   <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_n;
            match_cnt  <= match_n;
            armed      <= armed_n;
            timing_err <= err_n;
            if (load_dims) begin
                h_active <= eval_w;
                v_active <= eval_h;
            end
            if (frame_start || wdog_to)
                wdog <= '0;
            else
                wdog <= wdog + WDOG_W'(1);
        end
    end

    // pending is set after the accept edge, so a frame_start in the accept cycle cannot apply it.
    assign mode_req_ready = ~pending;
    assign accept         = mode_req_valid & ~pending;
    assign apply          = pending & ((state != LOCKED) | frame_start);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending     <= 1'b0;
            pend_mode   <= '0;
            mode_active <= '0;
            mode_update <= 1'b0;
        end else begin
            mode_update <= apply && (pend_mode != mode_active);
            if (apply) begin
                mode_active <= pend_mode;
                pending     <= 1'b0;
            end else if (accept) begin
                pending   <= 1'b1;
                pend_mode <= mode_req;
            end
        end
    end

endmodule

// File: tb/tb_video_path_ctrl.sv
// Directed bench for video_path_ctrl: frame-by-frame lock table plus mode, same-cycle accept and watchdog sequences.
module tb_video_path_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [1:0]  mode_req = 2'd0;
    logic        mode_req_valid = 1'b0;
    logic        mode_req_ready, mode_update, frame_start, line_start;
    logic        timing_locked, timing_err;
    logic [1:0]  mode_active;
    logic [11:0] h_active, v_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic        cap_fs, cap_fs2, cap_locked, cap_err, cap_err2, cap_upd, cap_rdy;
    logic [1:0]  cap_mode;
    logic [11:0] cap_h, cap_v;

    typedef struct {
        int nl;   int bad; int bw;
        int eh;   int ev;  int elk; int eerr;
    } vec_t;
    vec_t vecs[12];

    video_path_ctrl #(.H_CNT_W(12), .V_CNT_W(12), .LOCK_FRAMES(2), .WDOG_W(8), .MODE_W(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .vs_in          (vs_in),
        .hs_in          (hs_in),
        .de_in          (de_in),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .mode_req_ready (mode_req_ready),
        .mode_active    (mode_active),
        .mode_update    (mode_update),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .h_active       (h_active),
        .v_active       (v_active),
        .timing_locked  (timing_locked),
        .timing_err     (timing_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // vs high 3 cycles inside a 40-cycle vertical blank; optional request during the frame_start cycle.
    task automatic vs_part(input bit req, input logic [1:0] rv);
        vs_in = 1'b1;
        @(negedge clk);
        cap_fs = frame_start;
        if (req) begin
            mode_req       = rv;
            mode_req_valid = 1'b1;
        end
        @(negedge clk);
        mode_req_valid = 1'b0;
        cap_locked = timing_locked; cap_err = timing_err; cap_h = h_active; cap_v = v_active;
        cap_mode = mode_active; cap_upd = mode_update; cap_rdy = mode_req_ready;
        @(negedge clk);
        cap_err2 = timing_err;
        cap_fs2  = frame_start;
        vs_in    = 1'b0;
        cyc(37);
    endtask

    task automatic lines_part(input int nl, input int bad, input int bw);
        for (int l = 0; l < nl; l++) begin
            int w;
            w = (l == bad) ? bw : 16;
            de_in = 1'b1;
            @(negedge clk);
            check("line_start", line_start, 1);
            cyc(w - 1);
            de_in = 1'b0;
            cyc(4);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int errs;
        //        nl bad bw   eh  ev lk err
        vecs[0]  = '{4, -1, 16,  0, 0, 0, 0};
        vecs[1]  = '{4, -1, 16, 16, 4, 0, 0};
        vecs[2]  = '{4, -1, 16, 16, 4, 1, 0};
        vecs[3]  = '{4, -1, 16, 16, 4, 1, 0};
        vecs[4]  = '{4,  2, 15, 16, 4, 1, 0};
        vecs[5]  = '{4, -1, 16, 16, 4, 0, 1};
        vecs[6]  = '{4, -1, 16, 16, 4, 0, 0};
        vecs[7]  = '{4, -1, 16, 16, 4, 1, 0};
        vecs[8]  = '{3, -1, 16, 16, 4, 1, 0};
        vecs[9]  = '{4, -1, 16, 16, 3, 0, 1};
        vecs[10] = '{4, -1, 16, 16, 4, 0, 0};
        vecs[11] = '{4, -1, 16, 16, 4, 1, 0};

        // Reset asserted mid-line
        de_in = 1'b1;
        cyc(3);
        check("rst_ready", mode_req_ready, 1);
        check("rst_locked", timing_locked, 0);
        check("rst_dims", {h_active, v_active}, 0);
        check("rst_pulses", {frame_start, line_start, timing_err, mode_update}, 0);
        check("rst_mode", mode_active, 0);
        rstn = 1'b1;
        cyc(6);
        de_in = 1'b0;
        cyc(10);

        for (int i = 0; i < 12; i++) begin
            vs_part(1'b0, 2'd0);
            check($sformatf("v%0d_frame_start", i), cap_fs, 1);
            check($sformatf("v%0d_fs_width", i), cap_fs2, 0);
            check($sformatf("v%0d_h_active", i), cap_h, vecs[i].eh);
            check($sformatf("v%0d_v_active", i), cap_v, vecs[i].ev);
            check($sformatf("v%0d_locked", i), cap_locked, vecs[i].elk);
            check($sformatf("v%0d_err", i), cap_err, vecs[i].eerr);
            check($sformatf("v%0d_err_width", i), cap_err2, 0);
            lines_part(vecs[i].nl, vecs[i].bad, vecs[i].bw);
        end

        // Locked: mid-frame request waits for the next frame_start
        vs_part(1'b0, 2'd0);
        check("lk_locked", cap_locked, 1);
        mode_req = 2'd1; mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        check("lk_ready_drop", mode_req_ready, 0);
        lines_part(4, -1, 16);
        check("lk_mode_held", mode_active, 0);
        check("lk_ready_held", mode_req_ready, 0);
        vs_part(1'b0, 2'd0);
        check("lk_mode_applied", cap_mode, 1);
        check("lk_update", cap_upd, 1);
        check("lk_ready_back", cap_rdy, 1);
        lines_part(4, -1, 16);

        // Locked: accept in the frame_start cycle applies one frame later
        vs_part(1'b1, 2'd3);
        check("sc_mode_not_yet", cap_mode, 1);
        check("sc_ready_low", cap_rdy, 0);
        lines_part(4, -1, 16);
        vs_part(1'b0, 2'd0);
        check("sc_mode_applied", cap_mode, 3);
        check("sc_update", cap_upd, 1);
        check("sc_locked", cap_locked, 1);
        lines_part(4, -1, 16);

        // Watchdog: vs held low well past 2^8 cycles
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (timing_err) errs++;
        end
        check("wd_err_pulses", errs, 1);
        check("wd_locked", timing_locked, 0);

        // Unlocked: request applies the cycle after accept; repeat value gives no update
        mode_req = 2'd2; mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        check("ul_ready_drop", mode_req_ready, 0);
        check("ul_mode_before", mode_active, 3);
        @(negedge clk);
        check("ul_mode", mode_active, 2);
        check("ul_update", mode_update, 1);
        check("ul_ready", mode_req_ready, 1);
        @(negedge clk);
        check("ul_update_width", mode_update, 0);
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        @(negedge clk);
        check("ul_rep_mode", mode_active, 2);
        check("ul_rep_no_update", mode_update, 0);
        check("ul_rep_ready", mode_req_ready, 1);

        // First frame after timeout is partial: lock needs three frame_starts
        vs_part(1'b0, 2'd0);
        check("wd_fs1_locked", cap_locked, 0);
        check("wd_fs1_err", cap_err, 0);
        lines_part(4, -1, 16);
        vs_part(1'b0, 2'd0);
        check("wd_fs2_locked", cap_locked, 0);
        lines_part(4, -1, 16);
        vs_part(1'b0, 2'd0);
        check("wd_fs3_locked", cap_locked, 1);
        check("wd_fs3_dims", {cap_h, cap_v}, {12'd16, 12'd4});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
